// File: rtl/sb_tx_serial_ctrl.sv
// Sideband TX controller: pops 1..MAX_CHUNKS FIFO words per packet and streams them
// LSB-first as LANE_W-bit beats, followed by a mandatory low gap.
module sb_tx_serial_ctrl #(
  parameter int unsigned CHUNK_W    = 64,
  parameter int unsigned LANE_W     = 8,
  parameter int unsigned GAP_CYC    = 4,
  parameter int unsigned MAX_CHUNKS = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_flush,
  input  logic               i_fifo_empty,
  input  logic [CHUNK_W-1:0] i_fifo_rdata,
  input  logic               i_fifo_last,
  output logic               o_fifo_rd_en,
  output logic [LANE_W-1:0]  o_ser_data,
  output logic               o_ser_valid,
  output logic               o_pkt_done,
  output logic               o_drop,
  output logic               o_underrun,
  output logic               o_len_err,
  output logic               o_busy
);

  localparam int unsigned BEATS = CHUNK_W / LANE_W;
  localparam int unsigned BCW   = $clog2(BEATS);
  localparam int unsigned CCW   = $clog2(MAX_CHUNKS + 1);
  localparam int unsigned GCW   = (GAP_CYC < 2) ? 1 : $clog2(GAP_CYC + 1);

  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, GAP} state_t;
  // Outcome of the continuation check, resolved one beat before it takes effect
  typedef enum logic [1:0] {PF_NONE, PF_REQ, PF_URUN, PF_LEN} pf_t;

  state_t             state_q, state_d;
  pf_t                pf_q, pf_d;
  logic [CHUNK_W-1:0] shift_q, shift_d;
  logic [BCW-1:0]     beat_q, beat_d;
  logic [CCW-1:0]     chunk_q, chunk_d;
  logic [GCW-1:0]     gap_q, gap_d;
  logic               last_q, last_d;

  logic               rd_en_d, ser_valid_d, done_d, drop_d, urun_d, len_err_d, busy_d;
  logic [LANE_W-1:0]  ser_data_d;
  logic               load, load_first, emit, end_pkt, to_idle;

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    pf_d        = pf_q;
    shift_d     = shift_q;
    beat_d      = beat_q;
    chunk_d     = chunk_q;
    gap_d       = gap_q;
    last_d      = last_q;
    rd_en_d     = 1'b0;
    ser_data_d  = '0;
    ser_valid_d = 1'b0;
    done_d      = 1'b0;
    drop_d      = 1'b0;
    urun_d      = 1'b0;
    len_err_d   = 1'b0;
    busy_d      = 1'b0;
    load        = 1'b0;
    load_first  = 1'b0;
    emit        = 1'b0;
    end_pkt     = 1'b0;
    to_idle     = 1'b0;

    case (state_q)
      IDLE: begin
        if (o_fifo_rd_en) begin
          state_d = FETCH;
        end else if (!i_fifo_empty) begin
          rd_en_d = 1'b1;
        end
      end
      FETCH: begin
        if (i_fifo_rdata == '0) begin
          drop_d  = 1'b1;
          to_idle = 1'b1;
        end else begin
          load       = 1'b1;
          load_first = 1'b1;
        end
      end
      SHIFT: begin
        if (beat_q == BCW'(BEATS - 1)) begin
          if (pf_q == PF_REQ) load = 1'b1;
          else                end_pkt = 1'b1;
        end else begin
          emit = 1'b1;
          if (beat_q == BCW'(BEATS - 2)) begin
            urun_d    = (pf_q == PF_URUN);
            len_err_d = (pf_q == PF_LEN);
            done_d    = (GAP_CYC == 0) && (pf_q != PF_REQ);
          end
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          to_idle = 1'b1;
        end else begin
          gap_d  = gap_q - GCW'(1);
          done_d = (gap_q == GCW'(1));
        end
      end
      default: state_d = IDLE;
    endcase

    if (end_pkt) begin
      if (GAP_CYC == 0) begin
        to_idle = 1'b1;
      end else begin
        state_d = GAP;
        gap_d   = GCW'(GAP_CYC - 1);
        done_d  = (GAP_CYC == 1);
      end
    end

    // Returning to IDLE issues the next pop directly so packets stay GAP_CYC+2 apart
    if (to_idle) begin
      state_d = IDLE;
      rd_en_d = !i_fifo_empty;
    end

    if (load) begin
      state_d     = SHIFT;
      shift_d     = i_fifo_rdata >> LANE_W;
      ser_data_d  = i_fifo_rdata[LANE_W-1:0];
      ser_valid_d = 1'b1;
      beat_d      = '0;
      chunk_d     = load_first ? CCW'(1) : chunk_q + CCW'(1);
      last_d      = i_fifo_last;
      pf_d        = PF_NONE;
    end

    if (emit) begin
      shift_d     = shift_q >> LANE_W;
      ser_data_d  = shift_q[LANE_W-1:0];
      ser_valid_d = 1'b1;
      beat_d      = beat_q + BCW'(1);
    end

    // Continuation pop must be visible during beat BEATS-2 to land without a bubble
    if ((load || emit) && (beat_d == BCW'(BEATS - 2))) begin
      if (last_d) begin
        pf_d = PF_NONE;
      end else if (chunk_d < CCW'(MAX_CHUNKS)) begin
        if (i_fifo_empty) begin
          pf_d = PF_URUN;
        end else begin
          pf_d    = PF_REQ;
          rd_en_d = 1'b1;
        end
      end else begin
        pf_d = PF_LEN;
      end
    end

    if (i_flush) begin
      state_d     = IDLE;
      pf_d        = PF_NONE;
      shift_d     = '0;
      beat_d      = '0;
      chunk_d     = '0;
      gap_d       = '0;
      last_d      = 1'b0;
      rd_en_d     = 1'b0;
      ser_data_d  = '0;
      ser_valid_d = 1'b0;
      done_d      = 1'b0;
      drop_d      = 1'b0;
      urun_d      = 1'b0;
      len_err_d   = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      pf_q         <= PF_NONE;
      shift_q      <= '0;
      beat_q       <= '0;
      chunk_q      <= '0;
      gap_q        <= '0;
      last_q       <= 1'b0;
      o_fifo_rd_en <= 1'b0;
      o_ser_data   <= '0;
      o_ser_valid  <= 1'b0;
      o_pkt_done   <= 1'b0;
      o_drop       <= 1'b0;
      o_underrun   <= 1'b0;
      o_len_err    <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pf_q         <= pf_d;
      shift_q      <= shift_d;
      beat_q       <= beat_d;
      chunk_q      <= chunk_d;
      gap_q        <= gap_d;
      last_q       <= last_d;
      o_fifo_rd_en <= rd_en_d;
      o_ser_data   <= ser_data_d;
      o_ser_valid  <= ser_valid_d;
      o_pkt_done   <= done_d;
      o_drop       <= drop_d;
      o_underrun   <= urun_d;
      o_len_err    <= len_err_d;
      o_busy       <= busy_d;
    end
  end

endmodule
